register_file_nport: RTL
========================

Name: register_file_nport

Overview:
- Parametrised MIPS general-purpose register file; the successor to the single 32-bit register.
- Holds NREG words of WIDTH bits. Provides two combinational read ports and one synchronous write port with byte enables.
- Register 0 is hardwired to zero.
- Sits in the decode stage of the mips_stub datapath: rs/rt feed the ALU operands, and the writeback stage drives the write port.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8, minimum 8.
- NREG, 32, number of registers; power of two, minimum 2.
- AW, $clog2(NREG), address width (derived; not overridden by users).

Ports:
- cclk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request, sampled on rising cclk.
- wr_addr  input  AW  write register index.
- wr_be  input  WIDTH/8  byte enables; bit i covers data bits [8i+7:8i].
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  AW  read port A index.
- rd_data_a  output  WIDTH  read port A data.
- rd_addr_b  input  AW  read port B index.
- rd_data_b  output  WIDTH  read port B data.
- wr_count  output  16  number of committed writes since reset (saturating).

Behaviour:
- Reset:
  - rst high clears every register and wr_count to 0 immediately, without waiting for a clock edge.
  - While rst is high, rd_data_a and rd_data_b read 0 and writes are ignored.
  - Deasserting rst mid-operation loses no later write: the first rising edge with rst low is a normal cycle.
- Write:
  - On a rising cclk with rst low, wr_en=1 and wr_addr!=0, each byte of entry wr_addr with its wr_be bit set takes the matching byte of wr_data.
  - Bytes whose wr_be bit is clear keep their old value.
  - The new value is visible on the read ports 0 cycles after that edge (single-cycle write latency).
- Committed write:
  - Defined as wr_en=1, wr_addr!=0 and wr_be!=0.
  - Each committed write increments wr_count by 1; the count saturates at 16'hFFFF.
  - A write to entry 0, or with wr_be=0, is dropped and does not count.
- Read:
  - Purely combinational from the stored array: rd_data_x = entry[rd_addr_x].
  - rd_addr_x=0 always returns 0.
  - Both ports may address the same entry.
- Same-cycle read/write to the same address: reads return the OLD value until the edge, unless REGFILE_BYPASS_EN is defined (see Optional Feature).
- X handling: an unknown wr_addr with wr_en=1 must not corrupt entry 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port returns the byte-merged forwarded value in the same cycle when all of these hold:
  - wr_en=1 and wr_addr!=0;
  - rd_addr_x==wr_addr;
  - the port forwards wr_data bytes where wr_be is set and the stored bytes elsewhere.
- With the macro defined, the read path becomes combinational from the write inputs; this is the write-first behaviour needed for the 5-stage pipeline.
- Undefined: no forwarding; reads always reflect the stored state (read-first).

Decomposition:
- Package mips_pkg holds:
  - WORD_W=32 and REG_AW=5;
  - localparam REG_ZERO=0;
  - the byte-merge function merge_be(old, new, be), shared by storage and bypass.
- Sub-module register_nbit (WIDTH, per-byte write enable, asynchronous active-high clear) is the natural per-entry storage element.
  - It is instantiated NREG-1 times by a generate loop.
  - Entry 0 is a constant.
- Address decode, read muxes, bypass and the counter stay in register_file_nport.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then read every address on both ports -> all 0; wr_count=0.
- Full write/readback: write 32'hA5A5_0000+i to entries 1..31 with be=4'hF -> each reads back exactly; wr_count=31.
- Register 0 protection: write 32'hFFFF_FFFF to entry 0 -> rd_data_a(0)=0; wr_count unchanged.
- Byte enables: entry 5 holds 32'h1122_3344; write 32'hAABB_CCDD with be=4'b0101 -> reads 32'h11BB_33DD.
  - A following write with be=0 leaves 32'h11BB_33DD and does not count.
- Same-cycle hazard: write 32'hDEAD_BEEF to entry 7 while rd_addr_a=7.
  - Before the edge, rd_data_a shows the old value without the macro, or 32'hDEAD_BEEF with REGFILE_BYPASS_EN.
  - After the edge, both builds read 32'hDEAD_BEEF.
- Asynchronous reset mid-stream: assert rst between edges after writing entry 3 = 32'h1 -> rd_data reads 0 before the next edge.
  - After rst deasserts, the next write of 32'h2 to entry 3 lands; wr_count=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and the byte-merge helper used by register storage and the
// register-file forwarding path.
package mips_pkg;

   localparam int unsigned WORD_W   = 32'd32;
   localparam int unsigned REG_AW   = 32'd5;
   localparam int unsigned REG_ZERO = 32'd0;
   localparam int unsigned BYTE_W   = 32'd8;

   // merge_be works on a fixed wide container; callers widen their operands
   // and narrow the result, so any WIDTH up to MERGE_W shares this function.
   localparam int unsigned MERGE_W  = 32'd512;
   localparam int unsigned MERGE_BE = MERGE_W / BYTE_W;

   function automatic logic [MERGE_W-1:0] merge_be(
      input logic [MERGE_W-1:0]  old_word,
      input logic [MERGE_W-1:0]  new_word,
      input logic [MERGE_BE-1:0] be
   );
      logic [MERGE_W-1:0] merged;
      merged = old_word;
      for (int i = 32'sd0; i < MERGE_BE; i++) begin
         if (be[i]) begin
            merged[BYTE_W*i +: BYTE_W] = new_word[BYTE_W*i +: BYTE_W];
         end else begin
            merged[BYTE_W*i +: BYTE_W] = old_word[BYTE_W*i +: BYTE_W];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/register_nbit.sv
// WIDTH-bit storage register with per-byte write enables and an asynchronous
// active-high clear.
module register_nbit
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic               cclk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [WIDTH/8-1:0] wr_be,
   input  logic [WIDTH-1:0]   wr_data,
   output logic [WIDTH-1:0]   q
);

   logic [WIDTH-1:0] q_r;

   // Byte-merged storage update; bytes with a clear enable hold their value.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         q_r <= {WIDTH{1'b0}};
      end else if (wr_en) begin
         q_r <= WIDTH'(merge_be(MERGE_W'(q_r), MERGE_W'(wr_data), MERGE_BE'(wr_be)));
      end
   end

   assign q = q_r;

endmodule

// File: rtl/register_file_nport.sv
// NREG x WIDTH register file, two combinational read ports, one byte-enabled
// write port, entry 0 hardwired to zero. Optional macro: REGFILE_BYPASS_EN.
module register_file_nport
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int NREG  = 32,
   parameter int AW    = $clog2(NREG)
) (
   input  logic               cclk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [WIDTH/8-1:0] wr_be,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic [AW-1:0]      rd_addr_a,
   output logic [WIDTH-1:0]   rd_data_a,
   input  logic [AW-1:0]      rd_addr_b,
   output logic [WIDTH-1:0]   rd_data_b,
   output logic [15:0]        wr_count
);

   localparam int NBE = WIDTH / 8;

   logic [WIDTH-1:0] entry_s [NREG];
   logic [WIDTH-1:0] rd_data_a_s;
   logic [WIDTH-1:0] rd_data_b_s;
   logic             commit_s;
   logic [15:0]      wr_count_r;

   // Entry 0 is a constant, so no write address (known or not) can disturb it.
   assign entry_s[0] = {WIDTH{1'b0}};

   for (genvar g = 1; g < NREG; g++) begin : g_entry
      logic wr_sel_s;
      assign wr_sel_s = wr_en && (wr_addr == AW'(g));

      register_nbit #(.WIDTH(WIDTH)) u_reg (
         .cclk    (cclk),
         .rst     (rst),
         .wr_en   (wr_sel_s),
         .wr_be   (wr_be),
         .wr_data (wr_data),
         .q       (entry_s[g])
      );
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_ok_s;
   assign fwd_ok_s = !rst && wr_en && (wr_addr != AW'(REG_ZERO));

   // Write-first read ports: a matching in-flight write is merged over the stored word.
   always_comb begin
      if (fwd_ok_s && (rd_addr_a == wr_addr)) begin
         rd_data_a_s = WIDTH'(merge_be(MERGE_W'(entry_s[rd_addr_a]), MERGE_W'(wr_data),
                                       MERGE_BE'(wr_be)));
      end else begin
         rd_data_a_s = entry_s[rd_addr_a];
      end
      if (fwd_ok_s && (rd_addr_b == wr_addr)) begin
         rd_data_b_s = WIDTH'(merge_be(MERGE_W'(entry_s[rd_addr_b]), MERGE_W'(wr_data),
                                       MERGE_BE'(wr_be)));
      end else begin
         rd_data_b_s = entry_s[rd_addr_b];
      end
   end
`else
   // Read-first read ports straight from the stored array.
   always_comb begin
      rd_data_a_s = entry_s[rd_addr_a];
      rd_data_b_s = entry_s[rd_addr_b];
   end
`endif

   assign rd_data_a = rd_data_a_s;
   assign rd_data_b = rd_data_b_s;

   assign commit_s = wr_en && (wr_addr != AW'(REG_ZERO)) && (wr_be != {NBE{1'b0}});

   // Saturating count of writes that actually changed storage eligibility.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         wr_count_r <= 16'd0;
      end else if (commit_s && (wr_count_r != 16'hFFFF)) begin
         wr_count_r <= wr_count_r + 16'd1;
      end
   end

   assign wr_count = wr_count_r;

endmodule
